mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
Memory-mapped byte sink that sits on the CPU's store-side output bus (data_write, data, data_address) and serializes accepted bytes onto a UART TX line as 8N1 frames. A store to TX_ADDR pushes the byte into a FIFO. The CPU bus has no stall or ready path, so a store that arrives while the FIFO is full is dropped and recorded in a sticky overflow flag. A store to CTRL_ADDR clears that flag.

Parameters:
TX_ADDR, 32'hFFFF_FFF0, byte address whose stores enqueue data[7:0]
CTRL_ADDR, 32'hFFFF_FFF4, byte address whose stores with data[0]=1 clear overflow
CLKS_PER_BIT, 434, clk cycles per UART bit (>=2)
FIFO_DEPTH, 16, FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
data_write  input  1  store strobe from CPU, one cycle per store
data  input  8  store byte
data_address  input  32  store byte address
tx  output  1  UART serial out, idle high
busy  output  1  high whenever the FSM is not IDLE
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued (excludes the byte being shifted)
fifo_full  output  1  fifo_count==FIFO_DEPTH
overflow  output  1  sticky: at least one store was dropped

Behaviour:
- Reset values: tx=1, busy=0, fifo_count=0, fifo_full=0, overflow=0; FSM=IDLE; rd/wr pointers=0; baud counter=0; bit index=0.
- Reset applied mid-frame aborts the frame. tx=1 from the next cycle. All queued bytes are discarded.
- push = data_write && data_address==TX_ADDR. The full 32-bit compare is exact; any other address is ignored.
- Push accepted iff fifo_count<FIFO_DEPTH, or a pop occurs in the same cycle. An accepted push writes data at wr_ptr, and wr_ptr wraps modulo FIFO_DEPTH.
- Push rejected (full, no pop): byte is dropped and overflow<=1. No other state changes.
- clear = data_write && data_address==CTRL_ADDR && data[0]. It sets overflow<=0. Clear does not affect FIFO contents.
- All outputs are registered; fifo_count and overflow reflect a push/clear one cycle after the strobe.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If fifo_count!=0:
  - pop the head into shift_reg; rd_ptr++ (wraps)
  - baud_cnt<=0; state<=START; tx<=0 at the same edge
- START: hold tx=0. When baud_cnt==CLKS_PER_BIT-1:
  - baud_cnt<=0; bit_idx<=0; tx<=shift_reg[0]; state<=DATA
- DATA: hold the current bit. At each baud_cnt==CLKS_PER_BIT-1:
  - if bit_idx<7: bit_idx++, tx<=shift_reg[bit_idx+1]
  - else: tx<=1, state<=STOP
  - bits are sent LSB first
- STOP: hold tx=1. When baud_cnt==CLKS_PER_BIT-1: state<=IDLE.
- Every bit (start, d0..d7, stop) is exactly CLKS_PER_BIT cycles wide. Frame = 10*CLKS_PER_BIT cycles.
- Back-to-back frames are separated by exactly one IDLE cycle (tx=1). Frame period = 10*CLKS_PER_BIT+1.
- Simultaneous push and pop: fifo_count is unchanged, and both pointers advance.
- Simultaneous push and clear in one cycle is impossible, since it needs one address.
- Simultaneous drop and clear cannot occur in the same cycle either.
- busy=1 from the cycle tx first goes low until the cycle after the STOP bit ends.

Test Plan:
1. Reset, CLKS_PER_BIT=4, FIFO_DEPTH=16. Idle 20 cycles -> tx=1, busy=0, fifo_count=0, overflow=0 throughout.
2. One store of 0x55 to TX_ADDR:
   - fifo_count=1 for one cycle, then 0
   - tx samples every 4 cycles: 0,1,0,1,0,1,0,1,0,1
   - busy high for 40 cycles, then tx=1, busy=0
3. Stores of 0xA5 to 0xFFFF_FFF8 and to CTRL_ADDR with data=0x00 -> fifo_count stays 0, tx stays 1, overflow stays 0.
4. 18 consecutive stores 0x00..0x11 to TX_ADDR, one per cycle, CLKS_PER_BIT=4:
   - the first byte pops immediately, so 17 are accepted (0x00..0x10) and 0x11 is dropped
   - fifo_full=1, fifo_count=16, overflow=1
   - draining emits 0x00..0x10 in order with 41-cycle frame spacing
5. After scenario 4, store data=0x01 to CTRL_ADDR -> overflow=0 next cycle; fifo_count is unaffected.
6. Queue 0x3C, 0xC3; assert reset for 1 cycle during d3 of the first frame -> tx=1 and busy=0 after the reset edge, fifo_count=0, and no further frames are sent.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-bus byte sink feeding a FIFO
// and an 8N1 UART transmitter with sticky overflow.
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'hFFFF_FFF0,
  parameter logic [31:0] CTRL_ADDR    = 32'hFFFF_FFF4,
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          data_write,
  input  logic [7:0]                    data,
  input  logic [31:0]                   data_address,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, ovf_q;

  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q;

  logic push, clr, pop, push_ok, drop, baud_end;

  // Decode bus strobes and derive FIFO next count.
  always_comb begin
    push     = data_write && (data_address == TX_ADDR);
    clr      = data_write && (data_address == CTRL_ADDR) && data[0];
    pop      = (state_q == IDLE) && (cnt_q != '0);
    push_ok  = push && (!full_q || pop);
    drop     = push && !push_ok;
    baud_end = (baud_q == LAST);
    cnt_d    = cnt_q;
    if (push_ok && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !push_ok)
      cnt_d = cnt_q - CW'(1);
  end

  // FIFO storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      mem_q[wr_q] <= data;
  end

  // FIFO pointers, count, full and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (push_ok)
        wr_q <= wr_q + PW'(1);
      if (pop)
        rd_q <= rd_q + PW'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == FULL);
      if (clr)
        ovf_q <= 1'b0;
      else if (drop)
        ovf_q <= 1'b1;
    end
  end

  // Transmit FSM with registered tx and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= mem_q[rd_q];
            baud_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q != 3'd7) begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[bit_q + 3'd1];
            end else begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_count = cnt_q;
  assign fifo_full  = full_q;
  assign overflow   = ovf_q;

endmodule
